// File: rtl/ins_fetch_ctrl.sv
// Instruction-fetch sequencer: issues four big-endian byte reads per instruction,
// assembles the word and presents it to decode over a valid/ready handshake.
module ins_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 16
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        fetch_en,
  input  logic        pc_wr,
  input  logic [31:0] pc_in,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack,
  output logic [31:0] inst,
  output logic [31:0] pc_out,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic        misalign_err,
  output logic        bus_err,
  output logic        busy
);
  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, FETCH, VALID, ERR} state_t;

  state_t        state;
  logic [31:0]   pc;
  logic [1:0]    byte_cnt;
  logic [WW-1:0] wait_cnt;
  logic [31:0]   nxt_pc;

  // Address of the next instruction once decode takes the current one.
  assign nxt_pc = pc_wr ? pc_in : pc + 32'd4;

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state        <= IDLE;
      pc           <= RESET_PC;
      byte_cnt     <= 2'd0;
      wait_cnt     <= '0;
      inst         <= 32'd0;
      pc_out       <= RESET_PC;
      mem_req      <= 1'b0;
      mem_addr     <= 32'd0;
      inst_valid   <= 1'b0;
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;
      busy         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pc_wr) begin
            pc <= pc_in;
          end else if (fetch_en && pc[1:0] != 2'b00) begin
            state        <= ERR;
            misalign_err <= 1'b1;
          end else if (fetch_en) begin
            state    <= FETCH;
            byte_cnt <= 2'd0;
            wait_cnt <= '0;
            mem_req  <= 1'b1;
            mem_addr <= pc;
            busy     <= 1'b1;
          end
        end
        FETCH: begin
          if (pc_wr) begin
            // Redirect wins over any ack landing in the same cycle.
            state    <= IDLE;
            pc       <= pc_in;
            mem_req  <= 1'b0;
            busy     <= 1'b0;
            byte_cnt <= 2'd0;
          end else if (mem_req && mem_ack) begin
            inst[8*(3-byte_cnt) +: 8] <= mem_rdata;
            byte_cnt <= byte_cnt + 2'd1;
            wait_cnt <= '0;
            if (byte_cnt == 2'd3) begin
              state      <= VALID;
              mem_req    <= 1'b0;
              inst_valid <= 1'b1;
              pc_out     <= pc;
              busy       <= 1'b0;
            end else begin
              mem_addr <= pc + {30'd0, byte_cnt + 2'd1};
            end
          end else if (wait_cnt == WW'(TIMEOUT - 1)) begin
            state   <= ERR;
            mem_req <= 1'b0;
            bus_err <= 1'b1;
            busy    <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        VALID: begin
          if (inst_ready) begin
            inst_valid <= 1'b0;
            pc         <= nxt_pc;
            if (fetch_en && !pc_wr && nxt_pc[1:0] == 2'b00) begin
              state    <= FETCH;
              byte_cnt <= 2'd0;
              wait_cnt <= '0;
              mem_req  <= 1'b1;
              mem_addr <= nxt_pc;
              busy     <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end else if (pc_wr) begin
            inst_valid <= 1'b0;
            pc         <= pc_in;
            state      <= IDLE;
          end
        end
        ERR: begin
          mem_req    <= 1'b0;
          inst_valid <= 1'b0;
          if (pc_wr) begin
            pc           <= pc_in;
            misalign_err <= 1'b0;
            bus_err      <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ins_fetch_ctrl.sv
// Directed bench for ins_fetch_ctrl: byte-memory responder, scoreboard of expected
// instructions popped on each decode handshake, immediate-assertion checks.
module tb_ins_fetch_ctrl;
  localparam int TIMEOUT = 16;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        fetch_en, pc_wr, inst_ready, mem_ack;
  logic [31:0] pc_in;
  logic [7:0]  mem_rdata;
  logic        mem_req, inst_valid, misalign_err, bus_err, busy;
  logic [31:0] mem_addr, inst, pc_out;

  ins_fetch_ctrl #(.RESET_PC(32'h0), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .Reset(Reset), .fetch_en(fetch_en), .pc_wr(pc_wr), .pc_in(pc_in),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .inst(inst), .pc_out(pc_out), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .misalign_err(misalign_err), .bus_err(bus_err), .busy(busy)
  );

  always #5 CLK = ~CLK;

  typedef struct packed { logic [31:0] pc; logic [31:0] ins; } exp_t;
  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  function automatic logic [7:0] mb(input logic [31:0] a);
    logic [7:0] t;
    if (a[31:2] == 30'd0) begin
      case (a[1:0])
        2'd0: t = 8'h20;
        2'd1: t = 8'h08;
        2'd2: t = 8'h00;
        default: t = 8'h05;
      endcase
    end else begin
      t = a[7:0] * 8'd3;
      t = t + 8'h11;
    end
    return t;
  endfunction

  function automatic logic [31:0] word_at(input logic [31:0] p);
    return {mb(p), mb(p + 32'd1), mb(p + 32'd2), mb(p + 32'd3)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Memory responder: ack after ack_dly idle cycles, repeating while mem_req holds.
  int   ack_dly = 0;
  int   dly_cnt = 0;
  logic ack_en  = 1'b1;
  always @(negedge CLK) begin
    if (Reset && mem_req && ack_en) begin
      if (dly_cnt >= ack_dly) begin
        mem_ack   = 1'b1;
        mem_rdata = mb(mem_addr);
        dly_cnt   = 0;
      end else begin
        mem_ack = 1'b0;
        dly_cnt++;
      end
    end else begin
      mem_ack = 1'b0;
      dly_cnt = 0;
    end
  end

  // Scoreboard: every decode handshake must match the oldest expected instruction.
  always @(negedge CLK) begin
    if (Reset && inst_valid && inst_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_inst_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_inst", inst, e.ins);
        chk("sb_pc_out", pc_out, e.pc);
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_valid(input int max);
    int n;
    n = 0;
    while (!inst_valid && n < max) begin
      tick();
      n++;
    end
    if (!inst_valid) chk("wait_valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic push(input logic [31:0] p);
    exp_t e;
    e.pc  = p;
    e.ins = word_at(p);
    exp_q.push_back(e);
  endtask

  initial begin
    Reset = 1'b0; fetch_en = 0; pc_wr = 0; pc_in = 0; inst_ready = 0;
    mem_ack = 0; mem_rdata = 0;
    tick(); tick();
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_inst", inst, 0);
    chk("rst_pc_out", pc_out, 0);
    chk("rst_valid", inst_valid, 0);
    chk("rst_errs", {misalign_err, bus_err, busy}, 0);
    Reset = 1'b1;
    tick();

    // T1: first fetch from 0, ack every cycle, back-to-back into 4
    inst_ready = 1;
    push(32'h0);
    push(32'h4);
    fetch_en = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t1_mem_req", mem_req, 1);
      chk("t1_mem_addr", mem_addr, i);
      chk("t1_busy", busy, 1);
    end
    tick();
    chk("t1_valid_c5", inst_valid, 1);
    chk("t1_inst_c5", inst, 32'h2008_0005);
    chk("t1_pc_out_c5", pc_out, 0);
    chk("t1_req_c5", mem_req, 0);
    tick();
    chk("t1_b2b_req", mem_req, 1);
    chk("t1_b2b_addr", mem_addr, 32'h4);
    fetch_en = 0;
    wait_valid(20);
    tick();
    chk("t1_idle_valid", inst_valid, 0);

    // T2: PC=8, slow acks, decode stalls for 4 cycles
    ack_dly = 3;
    inst_ready = 0;
    push(32'h8);
    fetch_en = 1;
    tick();
    fetch_en = 0;
    wait_valid(40);
    for (int i = 0; i < 4; i++) begin
      chk("t2_hold_valid", inst_valid, 1);
      chk("t2_hold_inst", inst, word_at(32'h8));
      chk("t2_no_req", mem_req, 0);
      tick();
    end
    inst_ready = 1;
    tick();
    chk("t2_released", inst_valid, 0);

    // T3: redirect to 0x40 after the third byte was acked
    ack_dly = 0;
    fetch_en = 1;
    tick();
    chk("t3_addr0", mem_addr, 32'hC);
    fetch_en = 0;
    tick(); tick(); tick();
    chk("t3_addr3", mem_addr, 32'hF);
    pc_wr = 1; pc_in = 32'h40;
    tick();
    pc_wr = 0;
    chk("t3_req_drop", mem_req, 0);
    chk("t3_no_valid", inst_valid, 0);
    chk("t3_busy", busy, 0);
    tick();
    chk("t3_still_no_valid", inst_valid, 0);
    push(32'h40);
    fetch_en = 1;
    tick();
    fetch_en = 0;
    chk("t3_new_addr", mem_addr, 32'h40);
    chk("t3_new_req", mem_req, 1);
    wait_valid(20);
    tick();

    // T4: misaligned fetch, then recovery via redirect
    pc_wr = 1; pc_in = 32'h42;
    tick();
    pc_wr = 0; fetch_en = 1;
    tick();
    fetch_en = 0;
    chk("t4_misalign", misalign_err, 1);
    chk("t4_no_req", mem_req, 0);
    tick();
    chk("t4_misalign_held", misalign_err, 1);
    chk("t4_no_req2", mem_req, 0);
    pc_wr = 1; pc_in = 32'h44;
    tick();
    pc_wr = 0;
    chk("t4_cleared", misalign_err, 0);
    push(32'h44);
    fetch_en = 1;
    tick();
    fetch_en = 0;
    chk("t4_fetch_addr", mem_addr, 32'h44);
    chk("t4_fetch_req", mem_req, 1);
    wait_valid(20);
    tick();

    // T5: memory never answers -> bus error after TIMEOUT cycles
    ack_en = 0;
    fetch_en = 1;
    tick();
    fetch_en = 0;
    chk("t5_req_start", mem_req, 1);
    for (int i = 1; i < TIMEOUT; i++) tick();
    chk("t5_req_last", mem_req, 1);
    chk("t5_no_err_yet", bus_err, 0);
    tick();
    chk("t5_bus_err", bus_err, 1);
    chk("t5_req_off", mem_req, 0);
    ack_en = 1;
    pc_wr = 1; pc_in = 32'hFFFF_FFFC;
    tick();
    pc_wr = 0;
    chk("t5_cleared", bus_err, 0);

    // T6: fetch at top of memory wraps PC to 0, then reset mid-fetch
    push(32'hFFFF_FFFC);
    fetch_en = 1;
    tick();
    chk("t6_addr", mem_addr, 32'hFFFF_FFFC);
    wait_valid(20);
    tick();
    chk("t6_wrap_addr", mem_addr, 32'h0);
    chk("t6_wrap_req", mem_req, 1);
    fetch_en = 0;
    tick();
    Reset = 1'b0;
    #1;
    chk("t6_rst_req", mem_req, 0);
    chk("t6_rst_addr", mem_addr, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_inst", inst, 0);
    chk("t6_rst_pc_out", pc_out, 0);
    chk("t6_rst_valid", inst_valid, 0);
    tick();
    chk("sb_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
